// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/stop/lap/clear controller.
package stopwatch_pkg;

  // Default prescaler division: one count tick per second at a 100 MHz clock.
  localparam int unsigned SW_DIV_1HZ = 100_000_000;

  // Controller states; the encodings are visible on the status LEDs.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  // Prescaler width for a given division, never narrower than one bit.
  function automatic int unsigned swPreWidth(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler producing one enable tick every DIV cycles while running.
// A stopped prescaler keeps its value so a partial second survives a pause.
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV = SW_DIV_1HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load0,
  output logic tick
);

  localparam int unsigned W = swPreWidth(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] pre_q;
  logic [W-1:0] pre_d;

  // Next prescaler value: forced to zero, advanced with wrap, or held.
  always_comb begin
    pre_d = pre_q;
    if (load0) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + W'(1);
    end
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = run && (pre_q == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: turns the start/stop and lap/reset buttons into a
// four-state FSM, drives the seconds-counter enable and clear pulses, and
// tells the display path when to freeze the shown value.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV = SW_DIV_1HZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       cnt_enb,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] st
);

  sw_state_t state_q;
  sw_state_t state_d;
  logic      btnSs_q;
  logic      btnLr_q;
  logic      clr_q;
  logic      clr_d;
  logic      pressSs;
  logic      pressLr;
  logic      preLoad;
  logic      isRunning;

  // Rising-edge detection; the previous samples reset high so a button held
  // through reset must be released before it can register a press.
  assign pressSs = btn_ss & ~btnSs_q;
  assign pressLr = btn_lr & ~btnLr_q;

  // Counting is decided from the registered state only, which keeps the
  // count enable free of any combinational path from the buttons.
  assign isRunning = (state_q == RUN) || (state_q == LAP);

  // Next-state logic; start/stop has priority over lap/reset in every state.
  always_comb begin
    state_d = state_q;
    preLoad = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        preLoad = 1'b1;
        if (pressSs) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pressSs) begin
          state_d = STOP;
        end else if (pressLr) begin
          state_d = LAP;
        end
      end
      LAP: begin
        if (pressSs) begin
          state_d = STOP;
        end else if (pressLr) begin
          state_d = RUN;
        end
      end
      STOP: begin
        if (pressSs) begin
          state_d = RUN;
        end else if (pressLr) begin
          state_d = IDLE;
          preLoad = 1'b1;
          clr_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, button history and clear-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      btnSs_q <= 1'b1;
      btnLr_q <= 1'b1;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btnSs_q <= btn_ss;
      btnLr_q <= btn_lr;
      clr_q   <= clr_d;
    end
  end

  tick_gen #(
    .DIV(DIV)
  ) uTickGen (
    .clk  (clk),
    .rst  (rst),
    .run  (isRunning),
    .load0(preLoad),
    .tick (cnt_enb)
  );

  assign cnt_clr  = clr_q;
  assign lap_hold = (state_q == LAP);
  assign running  = isRunning;
  assign st       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DIV = 10.
module tb_stopwatch_ctrl;

  localparam int DIV = 10;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic       cnt_enb;
  logic       cnt_clr;
  logic       lap_hold;
  logic       running;
  logic [1:0] st;

  int tests = 0;
  int fails = 0;

  int mSt      = 0;
  int mPre     = 0;
  bit mClr     = 0;
  bit mSsPrev  = 1;
  bit mLrPrev  = 1;
  bit mPs      = 0;
  bit mPl      = 0;
  bit modelValid = 0;

  int pulses;

  stopwatch_ctrl #(
    .DIV(DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_lr  (btn_lr),
    .cnt_enb (cnt_enb),
    .cnt_clr (cnt_clr),
    .lap_hold(lap_hold),
    .running (running),
    .st      (st)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ss, input logic lr, input int cycles);
    btn_ss = ss;
    btn_lr = lr;
    repeat (cycles) @(negedge clk);
  endtask

  // Stopwatch behaviour model: state number, elapsed cycles within the
  // current second, and whether a clear was just issued.
  always @(posedge clk) begin
    if (!rst) begin
      mSt     = 0;
      mPre    = 0;
      mClr    = 0;
      mSsPrev = 1;
      mLrPrev = 1;
    end else begin
      mPs  = btn_ss && !mSsPrev;
      mPl  = btn_lr && !mLrPrev && !mPs;
      mClr = 0;
      if (mSt == 1 || mSt == 2) mPre = (mPre + 1) % DIV;
      case (mSt)
        0: if (mPs) begin mSt = 1; mPre = 0; end
        1: if (mPs) mSt = 3; else if (mPl) mSt = 2;
        2: if (mPs) mSt = 3; else if (mPl) mSt = 1;
        3: if (mPs) mSt = 1; else if (mPl) begin mSt = 0; mPre = 0; mClr = 1; end
        default: mSt = 0;
      endcase
      mSsPrev = btn_ss;
      mLrPrev = btn_lr;
    end
    modelValid = 1;
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("mdlSt",   st,       mSt);
      checkOutput("mdlEnb",  cnt_enb,  ((mSt == 1 || mSt == 2) && mPre == DIV - 1) ? 1 : 0);
      checkOutput("mdlClr",  cnt_clr,  mClr);
      checkOutput("mdlLap",  lap_hold, (mSt == 2) ? 1 : 0);
      checkOutput("mdlRun",  running,  (mSt == 1 || mSt == 2) ? 1 : 0);
    end
  end

  // Directed scenario with hand-computed expectations.
  initial begin
    rst    = 1'b0;
    btn_ss = 1'b1;
    btn_lr = 1'b0;

    // Reset with start/stop held down
    repeat (2) begin
      @(negedge clk);
      checkOutput("rstSt", st, 0);
      checkOutput("rstOut", {cnt_enb, cnt_clr, lap_hold, running}, 0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("heldSt", st, 0);
      checkOutput("heldRun", running, 0);
    end
    applyStimulus(0, 0, 1);
    checkOutput("relSt", st, 0);

    // Start and run 35 cycles: ticks at 10, 20, 30
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("startSt", st, 1);
    checkOutput("startRun", running, 1);
    pulses = 0;
    for (int k = 1; k <= 35; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput("enbRun", cnt_enb, (k % 10 == 0) ? 1 : 0);
      pulses += int'(cnt_enb);
    end
    checkOutput("enbCount", pulses, 3);

    // Stop with five cycles into the current second, pause 20 cycles
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("stopSt", st, 3);
    checkOutput("stopRun", running, 0);
    repeat (20) begin
      @(negedge clk);
      checkOutput("stopEnb", cnt_enb, 0);
    end

    // Resume: tick after 5 more cycles
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("resumeSt", st, 1);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput("resumeEnb", cnt_enb, (k == 5) ? 1 : 0);
    end

    // Lap: display holds, counting continues
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("lapHold", lap_hold, 1);
    checkOutput("lapSt", st, 2);
    for (int k = 8; k <= 26; k++) begin
      if (k > 8) @(negedge clk);
      checkOutput("lapEnb", cnt_enb, (k == 15 || k == 25) ? 1 : 0);
    end
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("unlapHold", lap_hold, 0);
    checkOutput("unlapSt", st, 1);
    for (int k = 27; k <= 35; k++) begin
      if (k > 27) @(negedge clk);
      checkOutput("unlapEnb", cnt_enb, (k == 35) ? 1 : 0);
    end

    // Stop exactly on a tick cycle: tick counts, next second starts fresh
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("tickStopSt", st, 3);
    checkOutput("tickStopEnb", cnt_enb, 0);
    repeat (3) @(negedge clk);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("tickRestartSt", st, 1);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput("tickRestartEnb", cnt_enb, (k == 10) ? 1 : 0);
    end

    // Both buttons together in RUN: start/stop wins
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("bothSt", st, 3);
    checkOutput("bothLap", lap_hold, 0);
    repeat (2) @(negedge clk);

    // Clear from STOP
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("clrSt", st, 0);
    checkOutput("clrPulse", cnt_clr, 1);
    @(negedge clk);
    checkOutput("clrDone", cnt_clr, 0);

    // Fresh start after clear: full second to first tick
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput("freshEnb", cnt_enb, (k == 10) ? 1 : 0);
    end
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("stop2St", st, 3);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("clr2Pulse", cnt_clr, 1);
    @(negedge clk);

    // Lap/reset in IDLE does nothing
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    checkOutput("idleLrSt", st, 0);
    checkOutput("idleLrClr", cnt_clr, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("idleLrQuiet", cnt_clr, 0);
    end

    // Reset in the middle of running
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("midSt", st, 1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstSt", st, 0);
    checkOutput("midRstOut", {cnt_enb, cnt_clr, lap_hold, running}, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("postRstSt", st, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/stop/lap/clear controller for the MM:SS stopwatch datapath. It turns two debounced push-buttons into a 4-state FSM. It generates the 1 Hz enable pulse that drives the seconds counter's enb input, and a clear pulse that zeroes the counter chain. A lap_hold level tells the display path to freeze the shown value while counting continues underneath.

Parameters:
DIV, 100_000_000, clock cycles per count tick (1 Hz at 100 MHz); legal range DIV >= 1; benches use DIV = 10.
W, $clog2(DIV) (minimum 1), prescaler width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-low reset; rst = 0 sampled at a rising clk edge resets the block.
btn_ss  in  1  start/stop button, debounced, synchronous to clk, level.
btn_lr  in  1  lap/reset button, debounced, synchronous to clk, level.
cnt_enb  out  1  one-cycle count enable for the seconds counter.
cnt_clr  out  1  one-cycle clear pulse for the counter chain.
lap_hold  out  1  level; display freezes while high.
running  out  1  high in RUN or LAP.
st  out  2  current state encoding, for status LEDs.

Behaviour:
- Press detection:
  - press_x = btn_x & ~btn_x_q, where btn_x_q is the previous-cycle sample.
  - btn_x_q resets to 1, so a button held through reset gives no press until it is released and pressed again.
  - A press is acted on at the same clock edge that samples it.
- State register st: IDLE = 0, RUN = 1, LAP = 2, STOP = 3. Reset value is IDLE.
- Transitions (anything not listed holds state):
  - IDLE: press_ss -> RUN, prescaler forced to 0. press_lr is ignored.
  - RUN: press_ss -> STOP. press_lr -> LAP.
  - LAP: press_ss -> STOP, hold released. press_lr -> RUN.
  - STOP: press_ss -> RUN, prescaler keeps its value so the partial second is preserved. press_lr -> IDLE, prescaler forced to 0, cnt_clr pulsed.
- Simultaneous press_ss and press_lr in the same cycle: press_ss wins and press_lr is discarded.
- Prescaler pre[W-1:0]:
  - In RUN or LAP: increments each cycle; when it reaches DIV-1 it wraps to 0 on the next edge.
  - In STOP: holds its value. In IDLE: held at 0.
- cnt_enb:
  - cnt_enb = (st is RUN or LAP) && pre == DIV-1.
  - It is decoded from registers only; there is no combinational path from the button inputs.
  - First pulse after IDLE->RUN appears in the DIV-th cycle after the transition edge.
  - With DIV = 1, cnt_enb is high every cycle while running.
- Stop coinciding with a tick (press_ss in RUN while pre == DIV-1):
  - cnt_enb is still high that cycle and the tick counts.
  - pre wraps to 0, st becomes STOP.
- cnt_clr:
  - Registered; high for exactly the one cycle following the STOP->IDLE edge (st already reads IDLE).
  - 0 at all other times, including during and after reset. The counter chain has its own reset.
- lap_hold = (st == LAP); running = st in {RUN, LAP}. Both are registered decodes.
- Reset asserted mid-operation: on the next edge st = IDLE, pre = 0, cnt_clr = 0, btn_*_q = 1. cnt_enb, lap_hold and running are therefore 0.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef enum logic [1:0] sw_state_t {IDLE, RUN, LAP, STOP} with the encodings above;
  - the default DIV constant, localparam SW_DIV_1HZ = 100_000_000.
- Sub-module tick_gen #(DIV) holds the prescaler. Ports: clk, rst, run (count), load0 (force 0), tick (pre == DIV-1 && run).
- Press detection and the FSM live in stopwatch_ctrl.

Test Plan (DIV = 10):
1. Reset: rst = 0 for 2 cycles with btn_ss held 1, then rst = 1 with btn_ss still held -> st = 0 and all outputs 0 throughout; no transition until btn_ss drops and rises again.
2. Start, then wait 35 cycles -> st = 1, running = 1, exactly 3 cnt_enb pulses at cycles 10, 20, 30 after the press edge, each 1 cycle wide.
3. Pause/resume: stop 15 cycles after start (pre = 5), idle 20 cycles, restart -> no cnt_enb while st = 3; next cnt_enb exactly 5 cycles after the restart edge.
4. Lap: press lr in RUN -> lap_hold = 1, st = 2, cnt_enb continues every 10 cycles; press lr again -> lap_hold = 0, st = 1.
5. Clear: in STOP press lr -> st = 0 and cnt_clr high exactly 1 cycle; a new start gives first cnt_enb 10 cycles later; press lr in IDLE -> no cnt_clr.
6. Coincidence cases:
   - both buttons pressed in the same cycle in RUN -> st = 3, lap_hold stays 0;
   - press_ss on a cycle where pre = 9 -> that cnt_enb is present, st = 3, and the restart tick comes 10 cycles after the restart edge.
